// File: rtl/qed_consistency_checker.sv
// qed_consistency_checker: counts QED original/duplicate commits and scans x[i] vs x[i+16] when they agree
module qed_consistency_checker #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             qed_ena,
  input  logic             commit_valid,
  input  logic [31:0]      commit_insn,
  output logic [4:0]       rf_raddr_orig,
  output logic [4:0]       rf_raddr_dup,
  input  logic [XLEN-1:0]  rf_rdata_orig,
  input  logic [XLEN-1:0]  rf_rdata_dup,
  output logic [CNT_W-1:0] orig_cnt,
  output logic [CNT_W-1:0] dup_cnt,
  output logic             qed_check_done,
  output logic             qed_mismatch,
  output logic [4:0]       qed_mismatch_reg,
  output logic             qed_order_err,
  output logic             qed_cnt_ovf
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_t state;
  logic dirty, is_qed, is_dup, counted, start, unused_insn;
  assign unused_insn = ^{commit_insn[31:20], commit_insn[18:12], commit_insn[10:7]};
  // classify the committing instruction and evaluate the scan start condition
  always_comb begin
    is_qed  = commit_insn[6:0] inside {7'b0000011, 7'b0010011, 7'b0110011, 7'b0100011};
    is_dup  = (commit_insn[6:0] == 7'b0100011) ? commit_insn[19] : commit_insn[11];
    counted = commit_valid & qed_ena & is_qed & ~qed_cnt_ovf;
    start   = (state == IDLE) & qed_ena & dirty & (orig_cnt == dup_cnt) & (orig_cnt != '0)
              & ~commit_valid & ~qed_cnt_ovf;
  end
  // saturating class counters with order and overflow flags; overflow freezes both counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      orig_cnt      <= '0;
      dup_cnt       <= '0;
      qed_order_err <= 1'b0;
      qed_cnt_ovf   <= 1'b0;
    end else if (counted) begin
      if (is_dup) begin
        dup_cnt <= dup_cnt + 1'b1;
        if (dup_cnt >= orig_cnt) qed_order_err <= 1'b1;
        if (dup_cnt == CNT_MAX - 1'b1) qed_cnt_ovf <= 1'b1;
      end else begin
        orig_cnt <= orig_cnt + 1'b1;
        if (orig_cnt == CNT_MAX - 1'b1) qed_cnt_ovf <= 1'b1;
      end
    end
  end
  // scan FSM: walks idx 1..15 through the registered read addresses, aborts on any commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      dirty            <= 1'b0;
      rf_raddr_orig    <= 5'd0;
      rf_raddr_dup     <= 5'd16;
      qed_check_done   <= 1'b0;
      qed_mismatch     <= 1'b0;
      qed_mismatch_reg <= 5'd0;
    end else begin
      dirty          <= counted ? 1'b1 : start ? 1'b0 : dirty;
      qed_check_done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state         <= SCAN;
          rf_raddr_orig <= 5'd1;
          rf_raddr_dup  <= 5'd17;
        end
        SCAN: begin
          if (rf_rdata_orig != rf_rdata_dup && !qed_mismatch) begin
            qed_mismatch     <= 1'b1;
            qed_mismatch_reg <= rf_raddr_orig;
          end
          if (commit_valid || rf_raddr_orig == 5'd15) begin
            state          <= commit_valid ? IDLE : DONE;
            qed_check_done <= ~commit_valid;
            rf_raddr_orig  <= 5'd0;
            rf_raddr_dup   <= 5'd16;
          end else begin
            rf_raddr_orig <= rf_raddr_orig + 5'd1;
            rf_raddr_dup  <= rf_raddr_dup + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qed_consistency_checker.sv
// tb_qed_consistency_checker: directed checks of counting, scan, abort, overflow and async reset
module tb_qed_consistency_checker;
  localparam logic [31:0] ADDI_O = 32'h00508193;
  localparam logic [31:0] ADDI_D = 32'h00588993;
  localparam logic [31:0] LW_X16 = 32'h00000803;
  localparam logic [31:0] MUL_X5 = 32'h020002B3;
  localparam logic [31:0] SW_X17 = 32'h00088023;
  localparam logic [31:0] BEQ    = 32'h00000063;
  logic clk = 1'b0;
  logic rst, qed_ena, commit_valid;
  logic [31:0] commit_insn;
  logic [31:0] rf [32];
  logic [4:0] ra_o, ra_d, ra4_o, ra4_d, mreg, mreg4;
  logic [31:0] rd_o, rd_d, rd4_o, rd4_d;
  logic [15:0] orig_cnt, dup_cnt;
  logic [3:0] orig4, dup4;
  logic done, mism, oerr, ovf, done4, mism4, oerr4, ovf4;
  int total = 0;
  int bad = 0;
  int n;
  assign rd_o  = rf[ra_o];
  assign rd_d  = rf[ra_d];
  assign rd4_o = rf[ra4_o];
  assign rd4_d = rf[ra4_d];
  always #5 clk = ~clk;

  qed_consistency_checker dut (
    .clk(clk), .rst(rst), .qed_ena(qed_ena), .commit_valid(commit_valid), .commit_insn(commit_insn),
    .rf_raddr_orig(ra_o), .rf_raddr_dup(ra_d), .rf_rdata_orig(rd_o), .rf_rdata_dup(rd_d),
    .orig_cnt(orig_cnt), .dup_cnt(dup_cnt), .qed_check_done(done), .qed_mismatch(mism),
    .qed_mismatch_reg(mreg), .qed_order_err(oerr), .qed_cnt_ovf(ovf)
  );

  qed_consistency_checker #(.XLEN(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .qed_ena(qed_ena), .commit_valid(commit_valid), .commit_insn(commit_insn),
    .rf_raddr_orig(ra4_o), .rf_raddr_dup(ra4_d), .rf_rdata_orig(rd4_o), .rf_rdata_dup(rd4_d),
    .orig_cnt(orig4), .dup_cnt(dup4), .qed_check_done(done4), .qed_mismatch(mism4),
    .qed_mismatch_reg(mreg4), .qed_order_err(oerr4), .qed_cnt_ovf(ovf4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    qed_ena = 1'b1;
    commit_valid = 1'b0;
    commit_insn = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic commit(input logic [31:0] insn);
    commit_valid = 1'b1;
    commit_insn = insn;
    step();
    commit_valid = 1'b0;
    commit_insn = '0;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!done && cnt < 40) begin
      step();
      cnt++;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + (i % 16);
    do_reset();
    chk("rst_orig", orig_cnt, 0);
    chk("rst_dup", dup_cnt, 0);
    chk("rst_done", done, 0);
    chk("rst_mism", mism, 0);
    chk("rst_mreg", mreg, 0);
    chk("rst_oerr", oerr, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_ra_o", ra_o, 0);
    chk("rst_ra_d", ra_d, 16);
    commit(BEQ);
    chk("ignored_op", orig_cnt, 0);
    commit(ADDI_O);
    chk("t1_orig1", orig_cnt, 1);
    chk("t1_dup0", dup_cnt, 0);
    commit(ADDI_D);
    chk("t1_dup1", dup_cnt, 1);
    chk("t1_idle", ra_o, 0);
    step();
    chk("t1_scan_ra_o", ra_o, 1);
    chk("t1_scan_ra_d", ra_d, 17);
    wait_done(n);
    chk("t1_latency", n, 15);
    chk("t1_mism", mism, 0);
    step();
    chk("t1_done_pulse", done, 0);
    repeat (20) step();
    chk("t1_no_rescan", ra_o, 0);

    do_reset();
    rf[7] = 32'hDEAD;
    rf[23] = 32'hBEEF;
    rf[9] = 32'h1;
    commit(ADDI_O);
    commit(ADDI_D);
    step();
    chk("t2_scan", ra_o, 1);
    wait_done(n);
    chk("t2_latency", n, 15);
    chk("t2_mism", mism, 1);
    chk("t2_mreg", mreg, 7);
    rf[7] = 32'h1007;
    rf[9] = 32'h1009;

    do_reset();
    commit(LW_X16);
    chk("t3_oerr", oerr, 1);
    chk("t3_dup", dup_cnt, 1);
    chk("t3_orig", orig_cnt, 0);
    repeat (20) step();
    chk("t3_no_scan", ra_o, 0);

    do_reset();
    commit(MUL_X5);
    commit(SW_X17);
    chk("t4_orig", orig_cnt, 1);
    chk("t4_dup", dup_cnt, 1);
    chk("t4_oerr", oerr, 0);
    step();
    chk("t4_scan", ra_o, 1);
    repeat (4) step();
    chk("t4_idx5", ra_o, 5);
    commit(ADDI_O);
    chk("t4_abort_ra", ra_o, 0);
    chk("t4_abort_done", done, 0);
    chk("t4_abort_orig", orig_cnt, 2);
    step();
    chk("t4_abort_idle", ra_o, 0);
    chk("t4_abort_done2", done, 0);
    commit(ADDI_D);
    chk("t4_dup2", dup_cnt, 2);
    step();
    chk("t4_rescan", ra_o, 1);
    wait_done(n);
    chk("t4_latency", n, 15);

    do_reset();
    for (int i = 0; i < 15; i++) commit(ADDI_O);
    chk("t5_orig4", orig4, 15);
    chk("t5_ovf4", ovf4, 1);
    chk("t5_orig16", orig_cnt, 15);
    chk("t5_ovf16", ovf, 0);
    for (int i = 0; i < 3; i++) commit(ADDI_D);
    chk("t5_dup4_frozen", dup4, 0);
    chk("t5_orig4_frozen", orig4, 15);
    chk("t5_oerr4", oerr4, 0);
    chk("t5_dup16", dup_cnt, 3);
    repeat (20) step();
    chk("t5_no_scan4", ra4_o, 0);

    do_reset();
    commit(ADDI_O);
    commit(ADDI_D);
    step();
    repeat (8) step();
    chk("t6_idx9", ra_o, 9);
    #2 rst = 1'b1;
    #1;
    chk("t6_orig", orig_cnt, 0);
    chk("t6_dup", dup_cnt, 0);
    chk("t6_ra_o", ra_o, 0);
    chk("t6_ra_d", ra_d, 16);
    chk("t6_done", done, 0);
    rst = 1'b0;
    repeat (20) step();
    chk("t6_idle", ra_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
